// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: states,
// opcodes, datapath mux selects and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IDLE   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output table: state (plus mem_ready for the handshake-qualified
// strobes) to datapath control word.
module mc_output_decode
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.aluSrcB = SRCB_FOUR;
        o_ctrl.aluOp   = ALUOP_ADD;
        o_ctrl.pcSource = PCSRC_ALU;
        o_ctrl.irWrite = i_mem_ready;
        o_ctrl.pcWrite = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.aluSrcB = SRCB_IMMSH;
        o_ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.memtoReg  = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.memWrite  = 1'b1;
        o_ctrl.iorD      = 1'b1;
        o_ctrl.instrDone = i_mem_ready;
      end
      S_EXEC: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_REG;
        o_ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.regDst    = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.aluSrcA     = 1'b1;
        o_ctrl.aluSrcB     = SRCB_REG;
        o_ctrl.aluOp       = ALUOP_SUB;
        o_ctrl.pcWriteCond = 1'b1;
        o_ctrl.pcSource    = PCSRC_ALUOUT;
        o_ctrl.instrDone   = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pcWrite   = 1'b1;
        o_ctrl.pcSource  = PCSRC_JUMP;
        o_ctrl.instrDone = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: state register and opcode-driven
// sequencing, with the output table delegated to mc_output_decode.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((Op == OP_LW) || (Op == OP_SW)) w_next = S_MEMADR;
        else if (Op == OP_RTYPE)            w_next = S_EXEC;
        else if (Op == OP_BEQ)              w_next = S_BRANCH;
        else if (Op == OP_J)                w_next = S_JUMP;
        else                                w_next = S_FETCH;
      end
      // Only lw/sw reach here, so anything but lw is treated as a store.
      S_MEMADR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RCOMP;
      S_RCOMP:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  mc_output_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pcWrite;
  assign PCWriteCond = w_ctrl.pcWriteCond;
  assign IorD        = w_ctrl.iorD;
  assign MemRead     = w_ctrl.memRead;
  assign MemWrite    = w_ctrl.memWrite;
  assign IRWrite     = w_ctrl.irWrite;
  assign MemtoReg    = w_ctrl.memtoReg;
  assign RegDst      = w_ctrl.regDst;
  assign RegWrite    = w_ctrl.regWrite;
  assign ALUSrcA     = w_ctrl.aluSrcA;
  assign ALUSrcB     = w_ctrl.aluSrcB;
  assign ALUOp       = w_ctrl.aluOp;
  assign PCSource    = w_ctrl.pcSource;
  assign instr_done  = w_ctrl.instrDone;
  assign illegal_op  = (r_state == S_DECODE) && !is_legal_op(Op);
  assign state       = r_state;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle MIPS main control unit. It replaces the single-cycle opcode decoder with a Moore-style state machine. It sequences the shared ALU, memory, instruction register and register file over several cycles per instruction, and stalls on a memory ready handshake. Its ALUOp output drives the existing ALU control decoder (00 add, 01 subtract, 10 funct field).

## Interface
Parameters: none; all encodings are fixed constants in the shared package.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces S_IDLE immediately
- Op  input  6  opcode field from the instruction register (IR[31:26])
- mem_ready  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  write register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B: 00 = reg B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  output  2  to ALU control decoder
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
- state  output  4  current state, for debug and verification

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010. Any other opcode is illegal.
- Any output not listed for a state is 0.
- S_IDLE (15): all outputs 0. Always advances to S_FETCH.
- S_FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- S_DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (computes branch target). Next state by Op:
  - lw/sw → S_MEMADR
  - R-type → S_EXEC
  - beq → S_BRANCH
  - j → S_JUMP
  - illegal → S_FETCH, with illegal_op=1 this cycle
- S_MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD (3): MemRead=1, IorD=1. Holds until mem_ready=1, then goes to S_MEMWB.
- S_MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Goes to S_FETCH.
- S_MEMWR (5): MemWrite=1, IorD=1. Holds until mem_ready=1; in that cycle instr_done=1, then goes to S_FETCH.
- S_EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to S_RCOMP.
- S_RCOMP (7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Goes to S_FETCH.
- S_BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to S_FETCH.
- S_JUMP (9): PCWrite=1, PCSource=10, instr_done=1. Goes to S_FETCH.
- Encodings 10–14 are unreachable. If entered, all outputs are 0 and the next state is S_IDLE.

## Timing
- Outputs are decoded combinationally from the state register. The only inputs that reach outputs combinationally are:
  - mem_ready → IRWrite, PCWrite and instr_done;
  - Op → illegal_op.
- Op is sampled only in S_DECODE and S_MEMADR; the IR is stable there by construction.
- Minimum latencies with zero wait states (mem_ready tied to 1):
  - lw: 5 cycles
  - R-type and sw: 4 cycles
  - beq and j: 3 cycles
- Each cycle of mem_ready=0 in S_FETCH, S_MEMRD or S_MEMWR adds exactly one cycle.
- Reset:
  - Asserting reset in any state, including mid-memory-access, sets state=15 asynchronously and drives all outputs to 0 within the same cycle.
  - After deassertion, the first rising edge moves to S_FETCH.
- mem_ready is ignored outside the three memory states.
- instr_done and illegal_op are never asserted in the same cycle.

## Structure
- Shared package `mc_pkg`:
  - state encodings S_FETCH..S_JUMP and S_IDLE
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
- The top level holds the state register and next-state logic.
- One combinational sub-module, `mc_output_decode` (state, mem_ready → control word), keeps the output table separate from the transition logic.

## Test plan
- Reset held with mem_ready=1 → state=15, all outputs 0; first edge after release → state=0, MemRead=1, IRWrite=1.
- Op=000000, mem_ready=1 → state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_done pulses once.
- Op=100011, mem_ready low for 2 cycles in S_MEMRD → sequence 0,1,2,3,3,3,4,0; total 7 cycles; MemtoReg=1 in state 4.
- Op=101011 then Op=000100 back to back, zero wait → sw takes 4 cycles with MemWrite=1 only in state 5; beq takes 3 cycles with PCWriteCond=1 and ALUOp=01 in state 8.
- Op=111111 → state 1 drives illegal_op=1, returns to state 0, and no RegWrite/MemWrite is asserted.
- Reset asserted mid-S_MEMWR with mem_ready=0 → MemWrite drops to 0 immediately; recovery starts from S_FETCH.
